servo_bank: RTL and testbench

Parametrised multi-channel servo PWM engine. Holds a double-buffered duty value per channel and generates staggered PWM outputs from one shared period counter. Duty updates arrive over a valid/ready write port and are committed only at each channel's own period boundary, so pulses are never glitched. It replaces the fixed 4-channel duty/period-finished multiplexing between the servo controller and the PWM pins.

---
 rtl/servo_pkg.sv | 17 +
 rtl/servo_bank_if.sv | 14 +
 rtl/servo_channel.sv | 77 +++++++
 rtl/servo_bank.sv | 68 ++++++
 tb/tb_servo_bank.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/servo_pkg.sv
// Shared constants, types and helpers for the servo PWM bank.
package servo_pkg;

   localparam int unsigned DefaultNumServos    = 4;
   localparam int unsigned DefaultDutyWidth    = 21;
   localparam int unsigned DefaultPeriodCycles = 2_000_000;

   typedef logic [DefaultDutyWidth-1:0] duty_t;

   // Channels are spread evenly over one period so their rising edges do not coincide.
   function automatic int unsigned phaseOffset(input int unsigned idx,
                                               input int unsigned numServos,
                                               input int unsigned period);
      return idx * (period / numServos);
   endfunction

endpackage

// File: rtl/servo_bank_if.sv
// Duty write port: valid/ready handshake plus a registered error pulse.
interface servo_bank_if #(
   parameter int unsigned SEL_WIDTH  = 2,
   parameter int unsigned DUTY_WIDTH = 21
);
   logic                  WrValid;
   logic                  WrReady;
   logic [SEL_WIDTH-1:0]  WrServo;
   logic [DUTY_WIDTH-1:0] WrDuty;
   logic                  WrError;

   modport master (output WrValid, WrServo, WrDuty, input WrReady, WrError);
   modport slave  (input WrValid, WrServo, WrDuty, output WrReady, WrError);
endinterface

// File: rtl/servo_channel.sv
// One PWM channel: shadow/active duty, boundary commit, registered outputs.
module servo_channel import servo_pkg::*; #(
   parameter int unsigned DUTY_WIDTH    = DefaultDutyWidth,
   parameter int unsigned PERIOD_CYCLES = DefaultPeriodCycles,
   parameter int unsigned OFFSET        = 0
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic [DUTY_WIDTH-1:0] Cnt,
   input  logic                  WrEn,
   input  logic [DUTY_WIDTH-1:0] WrDuty,
   input  logic                  Enable,
   output logic                  PwmOut,
   output logic                  PeriodFinished,
   output logic                  Pending
);

   // One extra bit so Cnt + PERIOD - OFFSET cannot overflow.
   localparam logic [DUTY_WIDTH:0] PeriodW   = (DUTY_WIDTH+1)'(PERIOD_CYCLES);
   localparam logic [DUTY_WIDTH:0] OffW      = (DUTY_WIDTH+1)'(OFFSET);
   localparam logic [DUTY_WIDTH:0] LastPhase = (DUTY_WIDTH+1)'(PERIOD_CYCLES - 1);

   logic [DUTY_WIDTH:0]   phaseRaw;
   logic [DUTY_WIDTH:0]   phase;
   logic                  commit;
   logic [DUTY_WIDTH-1:0] shadowQ;
   logic [DUTY_WIDTH-1:0] activeQ;
   logic                  pendingQ;
   logic                  pwmQ;
   logic                  commitQ;
   logic                  finishedQ;

   // Channel-local phase and period-end detect.
   always_comb begin
      phaseRaw = {1'b0, Cnt} + PeriodW - OffW;
      phase    = (phaseRaw >= PeriodW) ? phaseRaw - PeriodW : phaseRaw;
      commit   = (phase == LastPhase);
   end

   // Duty double buffer; a write in the commit cycle lands in shadow for the next period.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         shadowQ  <= '0;
         activeQ  <= '0;
         pendingQ <= 1'b0;
      end else begin
         if (commit) begin
            activeQ <= shadowQ;
         end
         if (WrEn) begin
            shadowQ  <= WrDuty;
            pendingQ <= 1'b1;
         end else if (commit) begin
            pendingQ <= 1'b0;
         end
      end
   end

   // Output registers; the finish pulse is delayed one extra cycle to line up with the
   // first high cycle of the new period.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         pwmQ      <= 1'b0;
         commitQ   <= 1'b0;
         finishedQ <= 1'b0;
      end else begin
         pwmQ      <= Enable && (phase < {1'b0, activeQ});
         commitQ   <= commit;
         finishedQ <= commitQ;
      end
   end

   assign PwmOut         = pwmQ;
   assign PeriodFinished = finishedQ;
   assign Pending        = pendingQ;

endmodule

// File: rtl/servo_bank.sv
// Multi-channel servo PWM bank: shared period counter, write decode, channel array.
module servo_bank import servo_pkg::*; #(
   parameter int unsigned NUM_SERVOS    = DefaultNumServos,
   parameter int unsigned DUTY_WIDTH    = DefaultDutyWidth,
   parameter int unsigned PERIOD_CYCLES = DefaultPeriodCycles,
   parameter int unsigned SEL_WIDTH     = (NUM_SERVOS > 1) ? $clog2(NUM_SERVOS) : 1
) (
   input  logic                  Clk,
   input  logic                  Reset,
   servo_bank_if.slave           Wr,
   input  logic [NUM_SERVOS-1:0] Enable,
   output logic [NUM_SERVOS-1:0] PwmOut,
   output logic [NUM_SERVOS-1:0] PeriodFinished,
   output logic [NUM_SERVOS-1:0] Pending
);

   localparam logic [DUTY_WIDTH-1:0] LastCnt = DUTY_WIDTH'(PERIOD_CYCLES - 1);

   logic [DUTY_WIDTH-1:0] cntQ;
   logic                  wrAccept;
   logic                  validIdx;
   logic                  wrErrorQ;
   logic [NUM_SERVOS-1:0] chWrEn;

   assign Wr.WrReady = !Reset;
   assign wrAccept   = Wr.WrValid && Wr.WrReady;
   assign validIdx   = (32'(Wr.WrServo) < NUM_SERVOS);
   assign Wr.WrError = wrErrorQ;

   // Shared period counter.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         cntQ <= '0;
      end else begin
         cntQ <= (cntQ == LastCnt) ? '0 : cntQ + 1'b1;
      end
   end

   // Out-of-range writes are accepted but dropped, flagged by a one-cycle pulse.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         wrErrorQ <= 1'b0;
      end else begin
         wrErrorQ <= wrAccept && !validIdx;
      end
   end

   for (genvar i = 0; i < NUM_SERVOS; i++) begin : gChannel
      assign chWrEn[i] = wrAccept && validIdx && (Wr.WrServo == SEL_WIDTH'(i));

      servo_channel #(
         .DUTY_WIDTH   (DUTY_WIDTH),
         .PERIOD_CYCLES(PERIOD_CYCLES),
         .OFFSET       (phaseOffset(i, NUM_SERVOS, PERIOD_CYCLES))
      ) uChannel (
         .Clk           (Clk),
         .Reset         (Reset),
         .Cnt           (cntQ),
         .WrEn          (chWrEn[i]),
         .WrDuty        (Wr.WrDuty),
         .Enable        (Enable[i]),
         .PwmOut        (PwmOut[i]),
         .PeriodFinished(PeriodFinished[i]),
         .Pending       (Pending[i])
      );
   end

endmodule

// File: tb/tb_servo_bank.sv
// Directed bench for servo_bank: 4-channel and 3-channel instances, period 100.
module tb_servo_bank;

   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic       Reset;
   logic [3:0] enable4, pwm4, pf4, pend4;
   logic [2:0] enable3, pwm3, pf3, pend3;

   servo_bank_if #(.SEL_WIDTH(2), .DUTY_WIDTH(8)) wr4 ();
   servo_bank_if #(.SEL_WIDTH(2), .DUTY_WIDTH(8)) wr3 ();

   servo_bank #(.NUM_SERVOS(4), .DUTY_WIDTH(8), .PERIOD_CYCLES(100)) u4 (
      .Clk           (Clk),
      .Reset         (Reset),
      .Wr            (wr4.slave),
      .Enable        (enable4),
      .PwmOut        (pwm4),
      .PeriodFinished(pf4),
      .Pending       (pend4)
   );

   servo_bank #(.NUM_SERVOS(3), .DUTY_WIDTH(8), .PERIOD_CYCLES(100)) u3 (
      .Clk           (Clk),
      .Reset         (Reset),
      .Wr            (wr3.slave),
      .Enable        (enable3),
      .PwmOut        (pwm3),
      .PeriodFinished(pf3),
      .Pending       (pend3)
   );

   // Reference period counter: equals the value the shared counter holds in the current cycle.
   int unsigned tbCnt;
   always @(posedge Clk) begin
      if (Reset) tbCnt <= 0;
      else       tbCnt <= (tbCnt == 99) ? 0 : tbCnt + 1;
   end

   int nVec = 0;
   int nMis = 0;
   int hiCnt[4];
   int pfCnt[4];
   logic [3:0] firstPwm, firstPf;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nVec++;
      if (got !== exp) begin
         nMis++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic waitCnt(input int unsigned n);
      int k = 0;
      while (tbCnt != n && k < 200) begin
         tick();
         k++;
      end
      if (tbCnt != n) checkEq("waitCnt", tbCnt, n);
   endtask

   task automatic write4(input int unsigned ch, input int unsigned duty);
      wr4.WrValid = 1'b1;
      wr4.WrServo = 2'(ch);
      wr4.WrDuty  = 8'(duty);
      tick();
      wr4.WrValid = 1'b0;
   endtask

   task automatic write3(input int unsigned ch, input int unsigned duty);
      wr3.WrValid = 1'b1;
      wr3.WrServo = 2'(ch);
      wr3.WrDuty  = 8'(duty);
      tick();
      wr3.WrValid = 1'b0;
   endtask

   // Sample 100 consecutive cycles of the 4-channel instance.
   task automatic measure();
      for (int c = 0; c < 4; c++) begin
         hiCnt[c] = 0;
         pfCnt[c] = 0;
      end
      for (int s = 0; s < 100; s++) begin
         tick();
         if (s == 0) begin
            firstPwm = pwm4;
            firstPf  = pf4;
         end
         for (int c = 0; c < 4; c++) begin
            if (pwm4[c]) hiCnt[c]++;
            if (pf4[c])  pfCnt[c]++;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      Reset       = 1'b1;
      enable4     = 4'hF;
      enable3     = 3'h7;
      wr4.WrValid = 1'b0;
      wr4.WrServo = '0;
      wr4.WrDuty  = '0;
      wr3.WrValid = 1'b0;
      wr3.WrServo = '0;
      wr3.WrDuty  = '0;

      // Reset state
      repeat (5) tick();
      checkEq("rstPwm", 32'(pwm4), 0);
      checkEq("rstPf", 32'(pf4), 0);
      checkEq("rstPend", 32'(pend4), 0);
      checkEq("rstWrErr", 32'(wr4.WrError), 0);
      checkEq("rstReady", 32'(wr4.WrReady), 0);
      checkEq("rstReady3", 32'(wr3.WrReady), 0);
      Reset = 1'b0;
      #1;
      checkEq("relReady", 32'(wr4.WrReady), 1);
      measure();
      checkEq("idlePwm", hiCnt[0] + hiCnt[1] + hiCnt[2] + hiCnt[3], 0);

      // Channel 2 write, commit at Cnt=49, pulse starts with the new period
      waitCnt(10);
      write4(2, 30);
      checkEq("wrPend", 32'(pend4), 32'h4);
      checkEq("wrErrValid", 32'(wr4.WrError), 0);
      waitCnt(50);
      checkEq("commitPend", 32'(pend4[2]), 0);
      checkEq("prePwm2", 32'(pwm4[2]), 0);
      checkEq("prePf2", 32'(pf4[2]), 0);
      measure();
      checkEq("risePwm2", 32'(firstPwm[2]), 1);
      checkEq("risePf2", 32'(firstPf[2]), 1);
      checkEq("hi2", hiCnt[2], 30);
      checkEq("pf2", pfCnt[2], 1);

      // Latest write wins before the boundary
      waitCnt(60);
      write4(1, 20);
      write4(1, 40);
      checkEq("pend1", 32'(pend4[1]), 1);
      waitCnt(25);
      measure();
      checkEq("latestWins", hiCnt[1], 40);

      // Write landing in the commit cycle applies one period later
      waitCnt(24);
      write4(1, 10);
      checkEq("collPend", 32'(pend4[1]), 1);
      measure();
      checkEq("collOld", hiCnt[1], 40);
      checkEq("collClr", 32'(pend4[1]), 0);
      measure();
      checkEq("collNew", hiCnt[1], 10);

      // Full-period duties and a disabled channel
      enable4 = 4'b0111;
      write4(0, 100);
      write4(2, 255);
      write4(3, 50);
      repeat (100) tick();
      checkEq("pendAll0", 32'(pend4), 0);
      measure();
      checkEq("hi0Full", hiCnt[0], 100);
      checkEq("hi2Full", hiCnt[2], 100);
      checkEq("hi3Off", hiCnt[3], 0);
      checkEq("pf3Off", pfCnt[3], 1);
      measure();
      checkEq("hi2Cont", hiCnt[2], 100);
      checkEq("pf3Again", pfCnt[3], 1);

      // Enable drop takes effect the next cycle
      enable4 = 4'b0110;
      tick();
      checkEq("enOff0", 32'(pwm4[0]), 0);
      enable4 = 4'b0111;
      tick();
      checkEq("enOn0", 32'(pwm4[0]), 1);

      // Out-of-range index on the 3-channel instance
      waitCnt(10);
      write3(0, 5);
      checkEq("u3ErrValid", 32'(wr3.WrError), 0);
      checkEq("u3Pend", 32'(pend3), 32'h1);
      write3(3, 7);
      checkEq("u3Err", 32'(wr3.WrError), 1);
      checkEq("u3PendKeep", 32'(pend3), 32'h1);
      tick();
      checkEq("u3ErrPulse", 32'(wr3.WrError), 0);

      // Reset in the middle of a channel 0 pulse
      write4(0, 60);
      waitCnt(0);
      waitCnt(31);
      checkEq("midPulse", 32'(pwm4[0]), 1);
      Reset = 1'b1;
      tick();
      checkEq("rstDrop", 32'(pwm4[0]), 0);
      checkEq("rstPend2", 32'(pend4), 0);
      checkEq("rstReady2", 32'(wr4.WrReady), 0);
      tick();
      Reset = 1'b0;
      measure();
      checkEq("postRst", hiCnt[0] + hiCnt[1] + hiCnt[2] + hiCnt[3], 0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule
